// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the multi-cycle RISC-V main controller: opcodes, FSM states,
// fault codes and the ALUOp/JumpType encodings driven to the datapath.
package riscv_ctrl_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_HALT   = 7'b1111111
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_IMEM    = 2'b10,
        FAULT_DMEM    = 2'b11
    } fault_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_UPPER  = 2'b11;

    localparam logic [1:0] JT_NONE = 2'b00;
    localparam logic [1:0] JT_JAL  = 2'b01;
    localparam logic [1:0] JT_JALR = 2'b10;

    // HALT is not listed here: it is recognised separately before legality is checked.
    function automatic logic opcode_legal(input logic [6:0] op, input logic en_upper);
        logic ok;
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR:        ok = 1'b1;
            OP_LUI, OP_AUIPC:                  ok = en_upper;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the main controller (master) and the datapath/memory
// side (slave): opcode and memory handshakes in, control strobes out.
interface multicycle_controller_if;
    logic [6:0] Opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       ImemReq;
    logic       IRWrite;
    logic       PCWrite;
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUOp;
    logic       Branch;
    logic       Jump;
    logic [1:0] JumpType;
    logic       Halt;
    logic [1:0] Fault;
    logic [2:0] State;

    modport master (
        input  Opcode, imem_ready, dmem_ready,
        output ImemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
               MemRead, MemWrite, ALUOp, Branch, Jump, JumpType,
               Halt, Fault, State
    );

    modport slave (
        output Opcode, imem_ready, dmem_ready,
        input  ImemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
               MemRead, MemWrite, ALUOp, Branch, Jump, JumpType,
               Halt, Fault, State
    );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Saturating wait counter for memory handshakes. expired flags the last allowed
// waiting cycle, so the FSM leaves after exactly TIMEOUT_CYCLES unanswered cycles.
module ctrl_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TIMEOUT_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int                   LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TIMEOUT_W-1:0] LAST_W = TIMEOUT_W'(LAST);
    localparam logic [TIMEOUT_W-1:0] SAT_W  = {TIMEOUT_W{1'b1}};

    logic [TIMEOUT_W-1:0] r_count;

    // Count waiting cycles; clear takes priority and the count never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run && (r_count != SAT_W)) begin
            r_count <= r_count + TIMEOUT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && run && (r_count >= LAST_W);

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of the multi-cycle RISC-V core: FETCH/DECODE/EXEC/MEM/WB sequencing
// with bounded memory waits, and sticky HALT/TRAP states that report a fault.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TIMEOUT_W      = 4,
    parameter int EN_UPPER_IMM   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    state_t     r_state;
    state_t     w_next_state;
    fault_t     r_fault;
    fault_t     w_next_fault;
    logic [6:0] r_op;

    logic w_run;
    logic w_ready;
    logic w_clear;
    logic w_expired;

    logic       w_imem_req, w_ir_write, w_pc_write, w_alu_src, w_mem_to_reg;
    logic       w_reg_write, w_mem_read, w_mem_write, w_branch, w_jump, w_halt;
    logic [1:0] w_alu_op, w_jump_type, w_fault;
    logic [2:0] w_state;

    assign w_ready = ((r_state == FETCH) && bus.imem_ready) ||
                     ((r_state == MEM)   && bus.dmem_ready);
    assign w_run   = ((r_state == FETCH) && !bus.imem_ready) ||
                     ((r_state == MEM)   && !bus.dmem_ready);
    assign w_clear = w_ready || (w_next_state != r_state);

    ctrl_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_W     (TIMEOUT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .run    (w_run),
        .expired(w_expired)
    );

    // State, fault and latched opcode registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_fault <= FAULT_NONE;
            r_op    <= 7'd0;
        end else begin
            r_state <= w_next_state;
            r_fault <= w_next_fault;
            if (r_state == DECODE) begin
                r_op <= bus.Opcode;
            end
        end
    end

    // Next-state logic; a ready arriving in the expiry cycle wins over the timeout.
    always_comb begin
        w_next_state = r_state;
        w_next_fault = r_fault;
        case (r_state)
            FETCH: begin
                if (bus.imem_ready) begin
                    w_next_state = DECODE;
                end else if (w_expired) begin
                    w_next_state = TRAP;
                    w_next_fault = FAULT_IMEM;
                end else begin
                    w_next_state = FETCH;
                end
            end
            DECODE: begin
                if (bus.Opcode == OP_HALT) begin
                    w_next_state = HALT;
                end else if (!opcode_legal(bus.Opcode, EN_UPPER_IMM != 0)) begin
                    w_next_state = TRAP;
                    w_next_fault = FAULT_ILLEGAL;
                end else begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                case (r_op)
                    OP_LOAD, OP_STORE:                w_next_state = MEM;
                    OP_REG, OP_IMM, OP_LUI, OP_AUIPC: w_next_state = WB;
                    OP_BRANCH, OP_JAL, OP_JALR:       w_next_state = FETCH;
                    default: begin
                        w_next_state = TRAP;
                        w_next_fault = FAULT_ILLEGAL;
                    end
                endcase
            end
            MEM: begin
                if (bus.dmem_ready) begin
                    w_next_state = (r_op == OP_STORE) ? FETCH : WB;
                end else if (w_expired) begin
                    w_next_state = TRAP;
                    w_next_fault = FAULT_DMEM;
                end else begin
                    w_next_state = MEM;
                end
            end
            WB:      w_next_state = FETCH;
            HALT:    w_next_state = HALT;
            TRAP:    w_next_state = TRAP;
            default: w_next_state = TRAP;
        endcase
    end

    // Control outputs from state and latched opcode; forced quiet while reset is held.
    always_comb begin
        w_imem_req   = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_op     = ALUOP_ADD;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_jump_type  = JT_NONE;
        w_halt       = 1'b0;
        w_fault      = 2'b00;
        w_state      = FETCH;
        if (reset) begin
            w_state = FETCH;
        end else begin
            w_state = r_state;
            w_fault = r_fault;
            case (r_state)
                FETCH: begin
                    w_imem_req = 1'b1;
                    w_ir_write = bus.imem_ready;
                end
                EXEC: begin
                    case (r_op)
                        OP_REG: w_alu_op = ALUOP_FUNCT;
                        OP_IMM: begin
                            w_alu_src = 1'b1;
                            w_alu_op  = ALUOP_FUNCT;
                        end
                        OP_LUI, OP_AUIPC: begin
                            w_alu_src = 1'b1;
                            w_alu_op  = ALUOP_UPPER;
                        end
                        OP_LOAD, OP_STORE: w_alu_src = 1'b1;
                        OP_BRANCH: begin
                            w_branch   = 1'b1;
                            w_alu_op   = ALUOP_BRANCH;
                            w_pc_write = 1'b1;
                        end
                        OP_JAL: begin
                            w_jump      = 1'b1;
                            w_jump_type = JT_JAL;
                            w_reg_write = 1'b1;
                            w_pc_write  = 1'b1;
                        end
                        OP_JALR: begin
                            w_alu_src   = 1'b1;
                            w_jump      = 1'b1;
                            w_jump_type = JT_JALR;
                            w_reg_write = 1'b1;
                            w_pc_write  = 1'b1;
                        end
                        default: w_alu_op = ALUOP_ADD;
                    endcase
                end
                MEM: begin
                    w_mem_read  = (r_op == OP_LOAD);
                    w_mem_write = (r_op == OP_STORE);
                    w_pc_write  = (r_op == OP_STORE) && bus.dmem_ready;
                end
                WB: begin
                    w_reg_write  = 1'b1;
                    w_pc_write   = 1'b1;
                    w_mem_to_reg = (r_op == OP_LOAD);
                end
                HALT:    w_halt = 1'b1;
                TRAP:    w_halt = 1'b1;
                default: w_halt = 1'b0;
            endcase
        end
    end

    assign bus.ImemReq  = w_imem_req;
    assign bus.IRWrite  = w_ir_write;
    assign bus.PCWrite  = w_pc_write;
    assign bus.ALUSrc   = w_alu_src;
    assign bus.MemtoReg = w_mem_to_reg;
    assign bus.RegWrite = w_reg_write;
    assign bus.MemRead  = w_mem_read;
    assign bus.MemWrite = w_mem_write;
    assign bus.ALUOp    = w_alu_op;
    assign bus.Branch   = w_branch;
    assign bus.Jump     = w_jump;
    assign bus.JumpType = w_jump_type;
    assign bus.Halt     = w_halt;
    assign bus.Fault    = w_fault;
    assign bus.State    = w_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (upper-immediate on/off) driven in
// lockstep and compared each cycle against per-instruction expected traces.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    localparam int TO   = 4;
    localparam int TAIL = 3;
    localparam int C_R = 0, C_I = 1, C_U = 2, C_LD = 3, C_ST = 4;
    localparam int C_BR = 5, C_JAL = 6, C_JALR = 7, C_HALT = 8, C_ILL = 9;

    typedef struct packed {
        logic       imemreq, irwrite, pcwrite, alusrc, memtoreg, regwrite, memread, memwrite;
        logic [1:0] aluop;
        logic       branch, jump;
        logic [1:0] jumptype;
        logic       halt;
        logic [1:0] fault;
        logic [2:0] state;
    } outv_t;

    typedef struct packed {
        logic       imr;
        logic       dmr;
        logic [6:0] opc;
    } inv_t;

    logic clk;
    logic reset;
    multicycle_controller_if bus_a ();
    multicycle_controller_if bus_b ();

    multicycle_controller #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(3), .EN_UPPER_IMM(1)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    multicycle_controller #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(3), .EN_UPPER_IMM(0)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    outv_t obs_a, obs_b;
    assign obs_a = {bus_a.ImemReq, bus_a.IRWrite, bus_a.PCWrite, bus_a.ALUSrc, bus_a.MemtoReg,
                    bus_a.RegWrite, bus_a.MemRead, bus_a.MemWrite, bus_a.ALUOp, bus_a.Branch,
                    bus_a.Jump, bus_a.JumpType, bus_a.Halt, bus_a.Fault, bus_a.State};
    assign obs_b = {bus_b.ImemReq, bus_b.IRWrite, bus_b.PCWrite, bus_b.ALUSrc, bus_b.MemtoReg,
                    bus_b.RegWrite, bus_b.MemRead, bus_b.MemWrite, bus_b.ALUOp, bus_b.Branch,
                    bus_b.Jump, bus_b.JumpType, bus_b.Halt, bus_b.Fault, bus_b.State};

    int    tests = 0;
    int    fails = 0;
    string step_name = "init";
    inv_t  q_in[$];
    outv_t q_t[$], q_a[$], q_b[$];
    bit    b_dead = 1'b0;
    outv_t b_dead_v;
    logic [6:0] ops [0:9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom);
    endfunction

    function automatic outv_t mk(input state_t s);
        outv_t v;
        v = '0;
        v.state = s;
        return v;
    endfunction

    function automatic int classify(input logic [6:0] op, input bit en);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0110111, 7'b0010111: return en ? C_U : C_ILL;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1111111: return C_HALT;
            default:    return C_ILL;
        endcase
    endfunction

    task automatic add(input bit rec, input outv_t v, input logic imr, input logic dmr,
                       input logic [6:0] opc);
        inv_t x;
        q_t.push_back(v);
        if (rec) begin
            x.imr = imr; x.dmr = dmr; x.opc = opc;
            q_in.push_back(x);
        end
    endtask

    task automatic tail(input bit rec, input outv_t v);
        repeat (TAIL) add(rec, v, rb(), rb(), ro());
    endtask

    // Expected cycle-by-cycle trace of one instruction from the latency/strobe rules.
    task automatic gen(input bit en, input bit rec, input logic [6:0] op, input int iw,
                       input int dw, output logic term);
        outv_t v;
        int    c;
        term = 1'b0;
        for (int k = 0; k < ((iw >= TO) ? TO : iw); k++) begin
            v = mk(FETCH); v.imemreq = 1'b1;
            add(rec, v, 1'b0, rb(), ro());
        end
        if (iw >= TO) begin
            v = mk(TRAP); v.halt = 1'b1; v.fault = 2'b10;
            tail(rec, v); term = 1'b1;
            return;
        end
        v = mk(FETCH); v.imemreq = 1'b1; v.irwrite = 1'b1;
        add(rec, v, 1'b1, rb(), ro());
        add(rec, mk(DECODE), rb(), rb(), op);
        c = classify(op, en);
        case (c)
            C_HALT: begin
                v = mk(HALT); v.halt = 1'b1; tail(rec, v); term = 1'b1;
            end
            C_ILL: begin
                v = mk(TRAP); v.halt = 1'b1; v.fault = 2'b01; tail(rec, v); term = 1'b1;
            end
            C_R, C_I, C_U: begin
                v = mk(EXEC); v.aluop = (c == C_U) ? 2'b11 : 2'b10; v.alusrc = (c != C_R);
                add(rec, v, rb(), rb(), ro());
                v = mk(WB); v.regwrite = 1'b1; v.pcwrite = 1'b1;
                add(rec, v, rb(), rb(), ro());
            end
            C_BR: begin
                v = mk(EXEC); v.branch = 1'b1; v.aluop = 2'b01; v.pcwrite = 1'b1;
                add(rec, v, rb(), rb(), ro());
            end
            C_JAL, C_JALR: begin
                v = mk(EXEC); v.jump = 1'b1; v.regwrite = 1'b1; v.pcwrite = 1'b1;
                v.jumptype = (c == C_JAL) ? 2'b01 : 2'b10; v.alusrc = (c == C_JALR);
                add(rec, v, rb(), rb(), ro());
            end
            C_LD, C_ST: begin
                v = mk(EXEC); v.alusrc = 1'b1;
                add(rec, v, rb(), rb(), ro());
                for (int k = 0; k < ((dw >= TO) ? TO : dw); k++) begin
                    v = mk(MEM); v.memread = (c == C_LD); v.memwrite = (c == C_ST);
                    add(rec, v, rb(), 1'b0, ro());
                end
                if (dw >= TO) begin
                    v = mk(TRAP); v.halt = 1'b1; v.fault = 2'b11;
                    tail(rec, v); term = 1'b1;
                end else begin
                    v = mk(MEM); v.memread = (c == C_LD); v.memwrite = (c == C_ST);
                    v.pcwrite = (c == C_ST);
                    add(rec, v, rb(), 1'b1, ro());
                    if (c == C_LD) begin
                        v = mk(WB); v.regwrite = 1'b1; v.pcwrite = 1'b1; v.memtoreg = 1'b1;
                        add(rec, v, rb(), rb(), ro());
                    end
                end
            end
            default: term = 1'b0;
        endcase
    endtask

    task automatic check(input string tag, input int cyc, input outv_t obs, input outv_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s step=%s cyc=%0d observed=%h expected=%h", tag, step_name, cyc, obs, exp);
        end
    endtask

    task automatic drive(input inv_t x);
        bus_a.imem_ready = x.imr; bus_a.dmem_ready = x.dmr; bus_a.Opcode = x.opc;
        bus_b.imem_ready = x.imr; bus_b.dmem_ready = x.dmr; bus_b.Opcode = x.opc;
    endtask

    task automatic do_reset();
        inv_t x;
        x.imr = rb(); x.dmr = rb(); x.opc = ro();
        reset = 1'b1;
        drive(x);
        @(negedge clk);
        check("reset_A", 0, obs_a, mk(FETCH));
        check("reset_B", 0, obs_b, mk(FETCH));
        @(posedge clk); #1;
        reset  = 1'b0;
        b_dead = 1'b0;
    endtask

    task automatic run_instr(input string name, input logic [6:0] op, input int iw,
                             input int dw, input int cut);
        logic ta, tb;
        int   n;
        step_name = name;
        q_in.delete(); q_t.delete();
        gen(1'b1, 1'b1, op, iw, dw, ta);
        q_a = q_t;
        q_t.delete();
        gen(1'b0, 1'b0, op, iw, dw, tb);
        q_b = q_t;
        if (b_dead) begin
            q_b.delete();
            repeat (q_a.size()) q_b.push_back(b_dead_v);
        end else begin
            while (q_b.size() > q_a.size()) void'(q_b.pop_back());
            while (q_b.size() < q_a.size()) q_b.push_back(q_b[$]);
            if (tb && !ta) begin
                b_dead   = 1'b1;
                b_dead_v = q_b[$];
            end
        end
        n = q_a.size();
        if (cut >= 0 && cut < n) n = cut + 1;
        for (int i = 0; i < n; i++) begin
            drive(q_in[i]);
            @(negedge clk);
            check("A", i, obs_a, q_a[i]);
            check("B", i, obs_b, q_b[i]);
            @(posedge clk); #1;
        end
        if (ta || (cut >= 0 && cut < q_a.size())) do_reset();
    endtask

    initial begin
        int idx, iw, dw, cut;
        logic [6:0] op;
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b1111111};
        reset = 1'b1;
        bus_a.imem_ready = 1'b0; bus_a.dmem_ready = 1'b0; bus_a.Opcode = 7'd0;
        bus_b.imem_ready = 1'b0; bus_b.dmem_ready = 1'b0; bus_b.Opcode = 7'd0;
        step_name = "reset";
        do_reset();

        run_instr("add",        7'b0110011, 0, 0, -1);
        run_instr("lw_wait3",   7'b0000011, 0, 3, -1);
        run_instr("jalr",       7'b1100111, 0, 0, -1);
        run_instr("lui",        7'b0110111, 0, 0, -1);
        run_instr("jal",        7'b1101111, 0, 0, -1);
        run_instr("beq",        7'b1100011, 1, 0, -1);
        run_instr("addi",       7'b0010011, 0, 0, -1);
        run_instr("auipc",      7'b0010111, 0, 0, -1);
        run_instr("sw",         7'b0100011, 0, 1, -1);
        run_instr("or",         7'b0110011, 2, 0, -1);
        run_instr("imem_tmo",   7'b0110011, 4, 0, -1);
        run_instr("imem_limit", 7'b0110011, 3, 0, -1);
        run_instr("halt",       7'b1111111, 0, 0, -1);
        run_instr("sw_reset",   7'b0100011, 0, 2, 3);
        run_instr("lw_limit",   7'b0000011, 0, 3, -1);
        run_instr("lw_tmo",     7'b0000011, 0, 4, -1);
        run_instr("illegal",    7'b0000000, 0, 0, -1);

        step_name = "random";
        for (int k = 0; k < 160; k++) begin
            idx = $urandom_range(0, 10);
            op  = (idx == 10) ? ro() : ops[idx];
            iw  = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 5) : $urandom_range(0, 2);
            dw  = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 5) : $urandom_range(0, 2);
            cut = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1;
            run_instr("random", op, iw, dw, cut);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
